// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register: FSM state encodings,
// MEM/WB control-bit positions and the default bubble control value.
package pipe_pkg;

    // State value equals the number of entries held, so it doubles as occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // MEM/WB control field layout: {MemtoReg, RegWrite}.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int MEMWB_CTRL_W  = 2;

    // A bubble carries no RegWrite and no MemtoReg.
    localparam logic [1:0] BUBBLE_CTRL_DEF = 2'b00;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready channel carrying {ctrl, data, tag} between pipeline stages.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
) ();

    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;

    // Producer side of the channel.
    modport master (
        output valid,
        output ctrl,
        output data,
        output tag,
        input  ready
    );

    // Consumer side of the channel.
    modport slave (
        input  valid,
        input  ctrl,
        input  data,
        input  tag,
        output ready
    );

endinterface

// File: rtl/pipe_entry.sv
// One payload slot of the stage: a load-enabled register with synchronous,
// active-low reset to zero.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int W = 71
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // Capture a new payload only when loaded; otherwise hold.
    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = d;
        end else begin
            val_d = val_q;
        end
    end

    // Payload register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush, and an optional
// second (skid) entry so that in_ready can come straight from a flop.
// Output payload is always taken from the main entry; the skid entry only
// catches the word accepted while the main entry is stalled.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter int                CTRL_W      = MEMWB_CTRL_W,
    parameter int                TAG_W       = 5,
    parameter bit                REG_READY   = 1'b1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEF)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              flush,
    pipe_stage_skid_if.slave  up,
    pipe_stage_skid_if.master dn,
    output logic [1:0]        occupancy
);

    localparam int ENT_W = CTRL_W + DATA_W + TAG_W;

    state_t             state_q;
    state_t             state_d;
    logic               accept_s;
    logic               pop_s;
    logic               out_valid_s;
    logic               in_ready_s;
    logic               main_load_s;
    logic               skid_load_s;
    logic               main_from_skid_s;
    logic [ENT_W-1:0]   in_ent_s;
    logic [ENT_W-1:0]   main_in_s;
    logic [ENT_W-1:0]   main_q_s;
    logic [ENT_W-1:0]   skid_q_s;

    assign in_ent_s    = {up.ctrl, up.data, up.tag};
    assign out_valid_s = (state_q != ST_EMPTY);

    // Handshake qualifiers for this cycle.
    always_comb begin
        accept_s = up.valid & in_ready_s;
        pop_s    = out_valid_s & dn.ready;
    end

    // Next state and entry write enables; flush overrides every transition.
    always_comb begin
        state_d          = state_q;
        main_load_s      = 1'b0;
        skid_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d     = ST_ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        main_load_s = 1'b1;
                    end else if (accept_s && REG_READY) begin
                        state_d     = ST_TWO;
                        skid_load_s = 1'b1;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        state_d          = ST_ONE;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Main entry is refilled from the skid when draining, else from upstream.
    always_comb begin
        main_in_s = in_ent_s;
        if (main_from_skid_s) begin
            main_in_s = skid_q_s;
        end else begin
            main_in_s = in_ent_s;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry #(.W(ENT_W)) u_main (
        .clk   (CLK),
        .rst_n (RSTn),
        .load  (main_load_s),
        .d     (main_in_s),
        .q     (main_q_s)
    );

    if (REG_READY) begin : g_skid
        logic in_ready_q;
        logic in_ready_d;

        // Ready for the next cycle is known from the next state alone.
        always_comb begin
            in_ready_d = (state_d != ST_TWO);
        end

        // Registered ready, low throughout reset.
        always_ff @(posedge CLK) begin
            if (!RSTn) begin
                in_ready_q <= 1'b0;
            end else begin
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready_s = in_ready_q;

        pipe_entry #(.W(ENT_W)) u_skid (
            .clk   (CLK),
            .rst_n (RSTn),
            .load  (skid_load_s),
            .d     (in_ent_s),
            .q     (skid_q_s)
        );
    end else begin : g_noskid
        logic unused_skid_load_s;

        // Single entry: accept whenever the held word leaves or none is held.
        assign in_ready_s         = RSTn & (~out_valid_s | dn.ready);
        assign skid_q_s           = '0;
        assign unused_skid_load_s = skid_load_s;
    end

    assign up.ready  = in_ready_s;
    assign dn.valid  = out_valid_s;
    assign dn.ctrl   = out_valid_s ? main_q_s[ENT_W-1 -: CTRL_W] : BUBBLE_CTRL;
    assign dn.data   = main_q_s[TAG_W +: DATA_W];
    assign dn.tag    = main_q_s[TAG_W-1:0];
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one skid-mode instance (dut1) and one
// single-entry instance (dut0), each with a scoreboard queue of expected
// payloads pushed on accept and popped on each output transfer.
module tb_pipe_stage_skid;

    localparam int PW = 71;

    logic       clk;
    logic       rstn;
    logic       iv1, or1, fl1;
    logic       iv0, or0, fl0;
    logic [1:0] occ1, occ0;
    logic [PW-1:0] pay1, pay0;

    logic [PW-1:0] q1[$];
    logic [PW-1:0] q0[$];

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_skid_if #(.CTRL_W(2), .DATA_W(64), .TAG_W(5)) up1 ();
    pipe_stage_skid_if #(.CTRL_W(2), .DATA_W(64), .TAG_W(5)) dn1 ();
    pipe_stage_skid_if #(.CTRL_W(2), .DATA_W(64), .TAG_W(5)) up0 ();
    pipe_stage_skid_if #(.CTRL_W(2), .DATA_W(64), .TAG_W(5)) dn0 ();

    assign up1.valid = iv1;
    assign up1.ctrl  = pay1[70:69];
    assign up1.data  = pay1[68:5];
    assign up1.tag   = pay1[4:0];
    assign dn1.ready = or1;

    assign up0.valid = iv0;
    assign up0.ctrl  = pay0[70:69];
    assign up0.data  = pay0[68:5];
    assign up0.tag   = pay0[4:0];
    assign dn0.ready = or0;

    pipe_stage_skid #(.REG_READY(1'b1)) dut1 (
        .CLK       (clk),
        .RSTn      (rstn),
        .flush     (fl1),
        .up        (up1),
        .dn        (dn1),
        .occupancy (occ1)
    );

    pipe_stage_skid #(.REG_READY(1'b0)) dut0 (
        .CLK       (clk),
        .RSTn      (rstn),
        .flush     (fl0),
        .up        (up0),
        .dn        (dn0),
        .occupancy (occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload derived from the tag: ctrl = tag[1:0], data halves tagged.
    function automatic logic [PW-1:0] mk(input logic [4:0] t);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'hA000_0000 | {27'd0, t};
        lo = 32'h5000_0000 | {27'd0, t};
        return {t[1:0], hi, lo, t};
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: scoreboard both DUTs mid-cycle, then step past the edge.
    task automatic cyc();
        logic [PW-1:0] exp;
        @(negedge clk);
        if (rstn) begin
            if (dn1.valid === 1'b1 && or1 === 1'b1) begin
                if (q1.size() > 0) exp = q1.pop_front();
                else               exp = {PW{1'bx}};
                chk("sb1_pop", {dn1.ctrl, dn1.data, dn1.tag}, exp);
            end
            if (fl1) q1.delete();
            else if (iv1 && up1.ready === 1'b1) q1.push_back(pay1);

            if (dn0.valid === 1'b1 && or0 === 1'b1) begin
                if (q0.size() > 0) exp = q0.pop_front();
                else               exp = {PW{1'bx}};
                chk("sb0_pop", {dn0.ctrl, dn0.data, dn0.tag}, exp);
            end
            if (fl0) q0.delete();
            else if (iv0 && up0.ready === 1'b1) q0.push_back(pay0);
            chk("occ0_never2", PW'(occ0 == 2'd2), PW'(1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        iv1 = 1'b1; or1 = 1'b1; fl1 = 1'b0; pay1 = mk(5'd31);
        iv0 = 1'b1; or0 = 1'b1; fl0 = 1'b0; pay0 = mk(5'd30);

        // 1: reset held three cycles with in_valid asserted
        repeat (3) cyc();
        chk("rst_valid1", PW'(dn1.valid), PW'(1'b0));
        chk("rst_occ1",   PW'(occ1),      PW'(2'd0));
        chk("rst_ctrl1",  PW'(dn1.ctrl),  PW'(2'd0));
        chk("rst_rdy1",   PW'(up1.ready), PW'(1'b0));
        chk("rst_valid0", PW'(dn0.valid), PW'(1'b0));
        chk("rst_rdy0",   PW'(up0.ready), PW'(1'b0));
        rstn = 1'b1; iv1 = 1'b0; iv0 = 1'b0;
        cyc();
        chk("rel_rdy1", PW'(up1.ready), PW'(1'b1));
        chk("rel_rdy0", PW'(up0.ready), PW'(1'b1));

        // 2: streaming tags 1..8, one cycle lag
        or1 = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            iv1 = 1'b1; pay1 = mk(5'(t));
            cyc();
            chk("stream_tag", PW'(dn1.tag), PW'(t));
            chk("stream_occ", PW'(occ1),    PW'(2'd1));
        end
        iv1 = 1'b0;
        cyc();
        chk("stream_drain_occ", PW'(occ1), PW'(2'd0));

        // 3: back-pressure fills the skid entry
        for (int t = 1; t <= 3; t++) begin
            iv1 = 1'b1; pay1 = mk(5'(t));
            cyc();
        end
        or1 = 1'b0; pay1 = mk(5'd4);
        cyc();
        chk("bp_occ2",  PW'(occ1),      PW'(2'd2));
        chk("bp_rdy0",  PW'(up1.ready), PW'(1'b0));
        chk("bp_tag3",  PW'(dn1.tag),   PW'(5'd3));
        pay1 = mk(5'd5);
        cyc();
        chk("bp_hold_occ", PW'(occ1),    PW'(2'd2));
        chk("bp_hold_tag", PW'(dn1.tag), PW'(5'd3));
        or1 = 1'b1;
        cyc();
        chk("bp_rel_tag4", PW'(dn1.tag),   PW'(5'd4));
        chk("bp_rel_occ",  PW'(occ1),      PW'(2'd1));
        chk("bp_rel_rdy",  PW'(up1.ready), PW'(1'b1));
        cyc();
        chk("bp_rel_tag5", PW'(dn1.tag), PW'(5'd5));
        iv1 = 1'b0;
        cyc();
        chk("bp_drain_occ", PW'(occ1), PW'(2'd0));

        // 4: flush at occupancy 2 with tag 9 offered
        or1 = 1'b0; iv1 = 1'b1; pay1 = mk(5'd6);
        cyc();
        pay1 = mk(5'd7);
        cyc();
        chk("fl_pre_occ", PW'(occ1), PW'(2'd2));
        pay1 = mk(5'd9); fl1 = 1'b1;
        cyc();
        chk("fl_occ",   PW'(occ1),      PW'(2'd0));
        chk("fl_valid", PW'(dn1.valid), PW'(1'b0));
        chk("fl_ctrl",  PW'(dn1.ctrl),  PW'(2'd0));
        fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        repeat (2) cyc();
        chk("fl_after_valid", PW'(dn1.valid), PW'(1'b0));

        // 5: flush coinciding with the pop of tag 6
        iv1 = 1'b1; pay1 = mk(5'd6);
        cyc();
        iv1 = 1'b0; fl1 = 1'b1;
        cyc();
        chk("flpop_occ",   PW'(occ1),      PW'(2'd0));
        chk("flpop_valid", PW'(dn1.valid), PW'(1'b0));
        fl1 = 1'b0;
        repeat (2) cyc();
        chk("flpop_after_valid", PW'(dn1.valid), PW'(1'b0));

        // 6: single-entry mode, combinational ready
        or0 = 1'b1; iv0 = 1'b1; pay0 = mk(5'd1);
        cyc();
        chk("nr_valid", PW'(dn0.valid), PW'(1'b1));
        or0 = 1'b0; pay0 = mk(5'd2);
        #1;
        chk("nr_rdy_low", PW'(up0.ready), PW'(1'b0));
        cyc();
        chk("nr_hold_occ", PW'(occ0),    PW'(2'd1));
        chk("nr_hold_tag", PW'(dn0.tag), PW'(5'd1));
        or0 = 1'b1;
        #1;
        chk("nr_rdy_high", PW'(up0.ready), PW'(1'b1));
        cyc();
        chk("nr_tag2", PW'(dn0.tag), PW'(5'd2));
        chk("nr_occ",  PW'(occ0),    PW'(2'd1));
        iv0 = 1'b0;
        cyc();
        chk("nr_drain_occ", PW'(occ0), PW'(2'd0));

        // Everything accepted and not flushed has been delivered.
        chk("sb1_empty", PW'(q1.size()), PW'(0));
        chk("sb0_empty", PW'(q0.size()), PW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
